// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; logic/arith ops finish in one cycle,
// SLL/SRL run on a bit-serial shifter at one bit per cycle.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_sh;
    logic [SHW-1:0]   r_cnt;
    logic             r_left;
    logic             r_zero;
    logic             r_illegal;

    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_shift_op;
    logic             w_legal;
    logic             w_slt;

    always_comb begin
        w_slt      = $signed(a) < $signed(b);
        w_shift_op = (alucontrol == 4'b1000) || (alucontrol == 4'b1001);
        w_legal    = w_shift_op || (alucontrol inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111});
        // Unlisted codes fall through to zero so the delivered result is 0.
        w_alu      = (alucontrol == 4'b0000) ? (a & b) :
                     (alucontrol == 4'b0001) ? (a | b) :
                     (alucontrol == 4'b0010) ? (a + b) :
                     (alucontrol == 4'b0110) ? (a - b) :
                     (alucontrol == 4'b0111) ? {{(WIDTH-1){1'b0}}, w_slt} : '0;
        w_sh_next  = r_left ? (r_sh << 1) : (r_sh >> 1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_left    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_illegal <= !w_legal;
                    if (w_shift_op) begin
                        r_sh   <= b;
                        r_cnt  <= shamt;
                        r_left <= !alucontrol[0];
                        if (shamt == '0) begin
                            r_result <= b;
                            r_zero   <= b == '0;
                            r_state  <= DONE;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end else begin
                        r_result <= w_alu;
                        r_zero   <= w_alu == '0;
                        r_state  <= DONE;
                    end
                end
                SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_sh_next;
                        r_zero   <= w_sh_next == '0;
                        r_state  <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    r_zero  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width in bits.
REQ-002 SHALL have parameter: SHW, 5, shift-amount width; SHW = log2(WIDTH).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 SHALL have port: in_valid  input  1  operation request valid.
REQ-006 SHALL have port: in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port: alucontrol  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRL.
REQ-008 SHALL have port: a  input  WIDTH  operand A (rs).
REQ-009 SHALL have port: b  input  WIDTH  operand B (rt or immediate); the shifted operand for SLL/SRL.
REQ-010 SHALL have port: shamt  input  SHW  shift amount for SLL/SRL; ignored otherwise.
REQ-011 SHALL have port: out_valid  output  1  result valid.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port: result  output  WIDTH  operation result.
REQ-014 SHALL have port: zero  output  1  result == 0.
REQ-015 SHALL have port: illegal  output  1  accepted alucontrol was not a listed code.

Function
REQ-016 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-017 SHALL assert in_ready exactly when the state is IDLE; the request is accepted on a cycle with in_valid && in_ready.
REQ-018 SHALL, on accepting AND/OR/ADD/SUB/SLT, register the result and enter DONE, so that out_valid is high on the cycle after acceptance (latency 1).
REQ-019 SHALL compute ADD/SUB modulo 2^WIDTH, with no overflow detection.
REQ-020 SHALL compute SLT as a signed compare: result = 1 if $signed(a) < $signed(b), else 0.
REQ-021 SHALL, on accepting SLL/SRL, load b into the shift register and load shamt into the down-counter.
REQ-022 SHALL, on accepting SLL/SRL with shamt == 0, go directly to DONE with result = b (latency 1).
REQ-023 SHALL, on accepting SLL/SRL with shamt != 0, enter SHIFT.
REQ-024 SHALL, in SHIFT, shift the register by 1 bit per cycle and decrement the counter: SLL shifts left and SRL shifts right, both zero-filling.
REQ-025 SHALL leave SHIFT for DONE on the cycle the counter decrements from 1 to 0, so total latency is shamt+1 cycles.
REQ-026 SHALL, on accepting an unlisted alucontrol code, set result = 0, zero = 1, illegal = 1 and enter DONE (latency 1).
REQ-027 SHALL clear illegal on every legal acceptance.
REQ-028 SHALL, in DONE, hold out_valid = 1 and keep result, zero and illegal stable until out_ready is sampled high.
REQ-029 SHALL, in DONE with out_ready high, return to IDLE next cycle, deassert out_valid, and assert in_ready in that same next cycle.
REQ-030 SHALL keep in_ready low in DONE even when out_ready is high in that cycle (no same-cycle re-accept); the maximum rate is one operation per 2 cycles.
REQ-031 SHALL ignore in_valid, a, b, shamt and alucontrol changes while in SHIFT or DONE.
REQ-032 SHALL derive zero from the registered result, and SHALL hold it low in IDLE and SHIFT.
REQ-033 SHALL never assert out_valid outside DONE.

Reset
REQ-034 SHALL, on a clk edge with reset_n low, set the state to IDLE, out_valid = 0, result = 0, zero = 0, illegal = 0, the counter to 0 and the shift register to 0.
REQ-035 SHALL, when reset is asserted mid-SHIFT or in DONE, abort the operation: no result is delivered, and in_ready = 1 on the first cycle after reset_n returns high.
REQ-036 SHALL give reset priority over every handshake event in the same cycle.

Verification
REQ-037 SHALL cover: ADD a=0xFFFFFFFF, b=1 -> out_valid 1 cycle after accept, result=0, zero=1, illegal=0.
REQ-038 SHALL cover: SLT a=0xFFFFFFFE (-2), b=3 -> result=1; then SUB a=5, b=7 -> result=0xFFFFFFFE, zero=0.
REQ-039 SHALL cover: SLL b=0x00000001, shamt=31 -> out_valid exactly 32 cycles after accept, result=0x80000000; SRL b=0x80000000, shamt=4 -> result=0x08000000 after 5 cycles; SLL shamt=0, b=0x1234 -> result=0x1234 after 1 cycle.
REQ-040 SHALL cover: out_ready held low 10 cycles in DONE -> result, zero and illegal constant, in_ready=0 throughout; in_valid pulses meanwhile are ignored.
REQ-041 SHALL cover: alucontrol=1111 -> result=0, zero=1, illegal=1; the following AND a=0xF0, b=0x3C -> result=0x30, illegal=0.
REQ-042 SHALL cover: reset_n low for 1 cycle at shift cycle 3 of SRL shamt=20 -> out_valid stays 0, and the state is IDLE with in_ready=1 on the next cycle.
